dual_beam_thresh_ctrl: RTL and testbench

- Control-side counterpart of the dual-beam trigger datapath. It drives the beam thresholds and consumes the beam triggers.
- Accepts threshold pairs through a valid/ready handshake and converts them to the two's-complement form the DSP threshold registers expect.
- Sequences the per-beam load strobes, then issues the update strobe.
- Counts the returned per-beam trigger bits over a fixed gate to produce saturating rate scalers.

---
 rtl/dual_beam_thresh_ctrl.sv | 150 +++++++++++++++
 tb/tb_dual_beam_thresh_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_beam_thresh_ctrl.sv
// Dual-beam threshold control: converts threshold pairs received over a
// valid/ready handshake into the negated form the DSP registers expect,
// sequences the per-beam load strobes and the apply strobe, and counts
// returned trigger bits over a fixed gate into saturating rate scalers.
module dual_beam_thresh_ctrl #(
  parameter int unsigned GATE_LEN = 1000000,
  parameter int unsigned SCAL_W   = 16,
  parameter int unsigned MASK_CYC = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [17:0]       req_thrA_i,
  input  logic [17:0]       req_thrB_i,
  output logic [17:0]       thresh_o,
  output logic [1:0]        thresh_ce_o,
  output logic              update_o,
  input  logic [1:0]        trigger_i,
  output logic [SCAL_W-1:0] scalerA_o,
  output logic [SCAL_W-1:0] scalerB_o,
  output logic              scaler_valid_o
);

  localparam int unsigned GW = (GATE_LEN > 1) ? $clog2(GATE_LEN) : 1;
  localparam int unsigned MW = $clog2(MASK_CYC + 1);
  localparam logic [GW-1:0]     GATE_LAST = GW'(GATE_LEN - 1);
  localparam logic [MW-1:0]     MASK_LOAD = MW'(MASK_CYC);
  localparam logic [SCAL_W-1:0] SCAL_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE,
    LOADA,
    LOADB,
    UPD
  } state_t;

  state_t            state;
  state_t            stateNext;
  logic [17:0]       thrBReg;
  logic              accept;
  logic [GW-1:0]     gateCnt;
  logic [MW-1:0]     maskCnt;
  logic              masked;
  logic              gateEnd;
  logic [SCAL_W-1:0] accA;
  logic [SCAL_W-1:0] accB;
  logic [SCAL_W-1:0] sumA;
  logic [SCAL_W-1:0] sumB;

  assign accept  = req_valid_i & req_ready_o;
  assign masked  = (maskCnt != '0);
  assign gateEnd = (gateCnt == GATE_LAST);

  // Next-state logic for the load sequencer
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (accept) stateNext = LOADA;
      LOADA:   stateNext = LOADB;
      LOADB:   stateNext = UPD;
      UPD:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Sequencer state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Registered outputs decoded from the next state so each strobe lines up
  // with the state it belongs to; LOADA is only reachable from an accept,
  // so the request inputs are still valid when it is decoded.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_ready_o <= 1'b0;
      thresh_o    <= '0;
      thresh_ce_o <= '0;
      update_o    <= 1'b0;
      thrBReg     <= '0;
    end else begin
      req_ready_o <= (stateNext == IDLE);
      thresh_ce_o <= '0;
      update_o    <= 1'b0;
      case (stateNext)
        LOADA: begin
          thresh_o    <= ~req_thrA_i + 18'd1;
          thresh_ce_o <= 2'b01;
          thrBReg     <= req_thrB_i;
        end
        LOADB: begin
          thresh_o    <= ~thrBReg + 18'd1;
          thresh_ce_o <= 2'b10;
        end
        UPD:     update_o <= 1'b1;
        default: ;
      endcase
    end
  end

  // Saturating increment of both accumulators with this cycle's unmasked triggers
  always_comb begin
    sumA = accA;
    sumB = accB;
    if (trigger_i[0] && !masked && (accA != SCAL_MAX)) sumA = accA + SCAL_W'(1);
    if (trigger_i[1] && !masked && (accB != SCAL_MAX)) sumB = accB + SCAL_W'(1);
  end

  // Trigger mask: reloaded by every update, counts down to unmasked
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      maskCnt <= '0;
    end else if (update_o) begin
      maskCnt <= MASK_LOAD;
    end else if (masked) begin
      maskCnt <= maskCnt - MW'(1);
    end
  end

  // Gate counter, accumulators and scaler transfer at gate end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gateCnt        <= '0;
      accA           <= '0;
      accB           <= '0;
      scalerA_o      <= '0;
      scalerB_o      <= '0;
      scaler_valid_o <= 1'b0;
    end else begin
      scaler_valid_o <= gateEnd;
      if (gateEnd) begin
        gateCnt   <= '0;
        scalerA_o <= sumA;
        scalerB_o <= sumB;
        accA      <= '0;
        accB      <= '0;
      end else begin
        gateCnt <= gateCnt + GW'(1);
        accA    <= sumA;
        accB    <= sumB;
      end
    end
  end

endmodule

// File: tb/tb_dual_beam_thresh_ctrl.sv
// Bench for dual_beam_thresh_ctrl: two instances (short gate / wide scaler,
// longer gate / narrow scaler) share the stimulus; a cycle model predicts
// sequencer outputs and pushes expected scaler reports into per-instance
// queues that are popped whenever an instance strobes scaler_valid_o.
module tb_dual_beam_thresh_ctrl;

  localparam int GLEN0 = 16;
  localparam int GLEN1 = 32;
  localparam int SMAX0 = 65535;
  localparam int SMAX1 = 15;
  localparam int MCYC  = 4;

  logic        clk = 1'b0;
  logic        rstN;
  logic        reqValid;
  logic [17:0] reqThrA;
  logic [17:0] reqThrB;
  logic [1:0]  trig;

  logic        ready0, ready1;
  logic [17:0] thresh0, thresh1;
  logic [1:0]  ce0, ce1;
  logic        upd0, upd1;
  logic [15:0] scA0, scB0;
  logic [3:0]  scA1, scB1;
  logic        sv0, sv1;

  always #5 clk = ~clk;

  dual_beam_thresh_ctrl #(.GATE_LEN(GLEN0), .SCAL_W(16), .MASK_CYC(MCYC)) u0 (
    .clk_i(clk), .rst_ni(rstN), .req_valid_i(reqValid), .req_ready_o(ready0),
    .req_thrA_i(reqThrA), .req_thrB_i(reqThrB), .thresh_o(thresh0),
    .thresh_ce_o(ce0), .update_o(upd0), .trigger_i(trig),
    .scalerA_o(scA0), .scalerB_o(scB0), .scaler_valid_o(sv0)
  );

  dual_beam_thresh_ctrl #(.GATE_LEN(GLEN1), .SCAL_W(4), .MASK_CYC(MCYC)) u1 (
    .clk_i(clk), .rst_ni(rstN), .req_valid_i(reqValid), .req_ready_o(ready1),
    .req_thrA_i(reqThrA), .req_thrB_i(reqThrB), .thresh_o(thresh1),
    .thresh_ce_o(ce1), .update_o(upd1), .trigger_i(trig),
    .scalerA_o(scA1), .scalerB_o(scB1), .scaler_valid_o(sv1)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef enum logic [1:0] {M_IDLE, M_LA, M_LB, M_UPD} mstate_t;
  typedef struct {
    int a;
    int b;
  } rep_t;

  mstate_t     mSt;
  logic        mReady;
  logic [1:0]  mCe;
  logic [17:0] mThr;
  logic [17:0] mThrB;
  logic        mUpd;
  int          gCnt[2];
  int          accA[2];
  int          accB[2];
  int          mask[2];
  logic        expValid[2];
  rep_t        q0[$];
  rep_t        q1[$];

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic mReset();
    mSt = M_IDLE; mReady = 1'b0; mCe = 2'b00; mThr = '0; mThrB = '0; mUpd = 1'b0;
    for (int i = 0; i < 2; i++) begin
      gCnt[i] = 0; accA[i] = 0; accB[i] = 0; mask[i] = 0; expValid[i] = 1'b0;
    end
    q0.delete();
    q1.delete();
  endtask

  // Advance the reference by one clock edge using the inputs now applied
  task automatic modelEdge();
    logic updOld;
    int incA, incB, sa, sb, gl, smax;
    rep_t r;
    updOld = mUpd;
    mCe = 2'b00;
    mUpd = 1'b0;
    case (mSt)
      M_IDLE: if (reqValid && mReady) begin
        mSt = M_LA; mThrB = reqThrB; mThr = 18'h0 - reqThrA; mCe = 2'b01;
      end
      M_LA: begin mSt = M_LB; mThr = 18'h0 - mThrB; mCe = 2'b10; end
      M_LB: begin mSt = M_UPD; mUpd = 1'b1; end
      default: mSt = M_IDLE;
    endcase
    mReady = (mSt == M_IDLE);
    for (int i = 0; i < 2; i++) begin
      gl   = (i == 0) ? GLEN0 : GLEN1;
      smax = (i == 0) ? SMAX0 : SMAX1;
      incA = (trig[0] && mask[i] == 0) ? 1 : 0;
      incB = (trig[1] && mask[i] == 0) ? 1 : 0;
      sa = accA[i] + incA; if (sa > smax) sa = smax;
      sb = accB[i] + incB; if (sb > smax) sb = smax;
      expValid[i] = 1'b0;
      if (gCnt[i] == gl - 1) begin
        r.a = sa; r.b = sb;
        if (i == 0) q0.push_back(r); else q1.push_back(r);
        expValid[i] = 1'b1; accA[i] = 0; accB[i] = 0; gCnt[i] = 0;
      end else begin
        accA[i] = sa; accB[i] = sb; gCnt[i]++;
      end
      if (updOld) mask[i] = MCYC;
      else if (mask[i] > 0) mask[i]--;
    end
  endtask

  task automatic checkOutputs();
    rep_t r;
    checkVal("ready", 32'(ready0), 32'(mReady));
    checkVal("u1 ready", 32'(ready1), 32'(mReady));
    checkVal("ce", 32'(ce0), 32'(mCe));
    checkVal("u1 ce", 32'(ce1), 32'(mCe));
    checkVal("thresh", 32'(thresh0), 32'(mThr));
    checkVal("u1 thresh", 32'(thresh1), 32'(mThr));
    checkVal("update", 32'(upd0), 32'(mUpd));
    checkVal("u1 update", 32'(upd1), 32'(mUpd));
    checkVal("u0 valid", 32'(sv0), 32'(expValid[0]));
    checkVal("u1 valid", 32'(sv1), 32'(expValid[1]));
    if (sv0 && q0.size() != 0) begin
      r = q0.pop_front();
      checkVal("u0 scalerA", 32'(scA0), 32'(r.a));
      checkVal("u0 scalerB", 32'(scB0), 32'(r.b));
    end
    if (sv1 && q1.size() != 0) begin
      r = q1.pop_front();
      checkVal("u1 scalerA", 32'(scA1), 32'(r.a));
      checkVal("u1 scalerB", 32'(scB1), 32'(r.b));
    end
  endtask

  // Called at a falling edge with inputs applied; returns at the next falling edge
  task automatic step();
    modelEdge();
    @(posedge clk);
    #1;
    cyc++;
    checkOutputs();
    @(negedge clk);
  endtask

  task automatic sendPair(input logic [17:0] a, input logic [17:0] b,
                          input logic [17:0] negA, input logic [17:0] negB);
    int tries;
    tries = 0;
    reqThrA = a; reqThrB = b; reqValid = 1'b1;
    do begin
      step();
      tries++;
    end while (ce0 != 2'b01 && tries < 10);
    reqValid = 1'b0;
    checkVal("accept seen", 32'(ce0), 32'h1);
    checkVal("negated A", 32'(thresh0), 32'(negA));
    step();
    checkVal("ce B", 32'(ce0), 32'h2);
    checkVal("negated B", 32'(thresh0), 32'(negB));
    step();
    checkVal("update pulse", 32'(upd0), 32'h1);
    step();
    checkVal("ready back", 32'(ready0), 32'h1);
    checkVal("update done", 32'(upd0), 32'h0);
  endtask

  initial begin
    int seen, tries, cnt;
    int accCyc[3];
    logic [17:0] pa[3];
    logic [17:0] pb[3];
    pa[0] = 18'd5;     pb[0] = 18'd6;
    pa[1] = 18'h1FFFF; pb[1] = 18'd1;
    pa[2] = 18'h0ABCD; pb[2] = 18'h20000;

    rstN = 1'b0; reqValid = 1'b0; reqThrA = '0; reqThrB = '0; trig = 2'b00;
    repeat (3) @(negedge clk);
    checkVal("reset ready", 32'(ready0), 32'h0);
    checkVal("reset ce", 32'(ce0), 32'h0);
    checkVal("reset thresh", 32'(thresh0), 32'h0);
    checkVal("reset update", 32'(upd0), 32'h0);
    checkVal("reset scalerA", 32'(scA0), 32'h0);
    checkVal("reset scalerB", 32'(scB1), 32'h0);
    checkVal("reset valid", 32'(sv0), 32'h0);
    rstN = 1'b1;
    mReset();
    trig = 2'b01;
    step();
    checkVal("ready after reset", 32'(ready0), 32'h1);

    sendPair(18'd100, 18'h3FFFF, 18'h3FF9C, 18'h00001);
    sendPair(18'h00000, 18'h20000, 18'h00000, 18'h20000);

    // Three pairs offered with valid held high
    seen = 0; tries = 0;
    reqValid = 1'b1; reqThrA = pa[0]; reqThrB = pb[0];
    while (seen < 3 && tries < 40) begin
      step();
      tries++;
      if (ce0 == 2'b01) begin
        accCyc[seen] = cyc;
        seen++;
        if (seen < 3) begin reqThrA = pa[seen]; reqThrB = pb[seen]; end
      end
    end
    reqValid = 1'b0;
    checkVal("b2b accepts", 32'(seen), 32'd3);
    checkVal("b2b spacing 1", 32'(accCyc[1] - accCyc[0]), 32'd4);
    checkVal("b2b spacing 2", 32'(accCyc[2] - accCyc[1]), 32'd4);

    // Steady beam A triggers with no requests
    repeat (40) step();

    // Request landing mid-gate so its mask falls inside one short gate
    tries = 0;
    while (gCnt[0] != 2 && tries < 20) begin step(); tries++; end
    sendPair(18'd7, 18'd9, 18'h3FFF9, 18'h3FFF7);
    repeat (30) step();

    // Both beams constant: narrow scaler saturates
    trig = 2'b11;
    repeat (70) step();

    // Beam B trigger only in the last cycle of the long gate
    for (int k = 0; k < 100; k++) begin
      trig = (gCnt[1] == GLEN1 - 1) ? 2'b10 : 2'b00;
      step();
    end
    trig = 2'b01;

    // Reset while the B threshold is being loaded
    tries = 0;
    reqThrA = 18'd33; reqThrB = 18'd44; reqValid = 1'b1;
    do begin step(); tries++; end while (ce0 != 2'b01 && tries < 10);
    reqValid = 1'b0;
    step();
    checkVal("in LOADB", 32'(ce0), 32'h2);
    rstN = 1'b0;
    #1;
    checkVal("async ce", 32'(ce0), 32'h0);
    checkVal("async thresh", 32'(thresh0), 32'h0);
    checkVal("async update", 32'(upd0), 32'h0);
    checkVal("async ready", 32'(ready0), 32'h0);
    checkVal("async scaler", 32'(scA0), 32'h0);
    mReset();
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    cnt = 0;
    do begin step(); cnt++; end while (!sv0 && cnt < 40);
    checkVal("first gate after reset", 32'(cnt), 32'd16);
    repeat (20) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
